// File: rtl/ex_div_unit_if.sv
// ex_div_unit_if: the request/result bundle between the execute stage and the
// iterative divider.
//
// Handshake: EX raises start_i with the operands and keeps it high until it
// sees ready_o.  The divider holds ready_o and result_o for as long as start_i
// stays high.  Dropping start_i releases the result, and ready_o/result_o
// clear on the next edge.  annul_i squashes an operation that is in flight.
//
// Signals:
//   signed_div_i  1 = DIV (signed), 0 = DIVU (unsigned)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held until ready_o
//   annul_i       cancel an in-flight division
//   result_o      {remainder, quotient}
//   ready_o       result valid
//   busy_o        divider not idle
// Modports: master = execute stage, slave = divider.
interface ex_div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/ex_div_unit.sv
// ex_div_unit: radix-2 restoring divider for DIV/DIVU.  It produces one
// quotient bit per cycle and returns {remainder, quotient} for HI/LO.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   bus        ex_div_unit_if.slave (operands, start/annul, result/ready/busy)
//   dbg_state  current FSM state, for observation only
module ex_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    ex_div_unit_if.slave        bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [2*DATA_W:0]      work, work_n;
    logic [DATA_W-1:0]      divisor, divisor_n;
    logic                   neg1, neg1_n;
    logic                   neg2, neg2_n;
    logic [2*DATA_W-1:0]    result, result_n;
    logic                   ready, ready_n;

    logic [DATA_W-1:0]      dividend_mag;
    logic [DATA_W-1:0]      divisor_mag;
    logic [DATA_W:0]        diff;
    logic [DATA_W-1:0]      quot_fix;
    logic [DATA_W-1:0]      rem_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FREE;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            result  <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            work    <= work_n;
            divisor <= divisor_n;
            neg1    <= neg1_n;
            neg2    <= neg2_n;
            result  <= result_n;
            ready   <= ready_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        neg1_n    = neg1;
        neg2_n    = neg2;
        result_n  = result;
        ready_n   = ready;

        // Signed operands are divided as magnitudes.  The signs are
        // reapplied at finalise.
        dividend_mag = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ?
                       -bus.opdata1_i : bus.opdata1_i;
        divisor_mag  = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ?
                       -bus.opdata2_i : bus.opdata2_i;

        // The partial remainder lives in work[63:32].  The extra top bit of
        // diff acts as the borrow, so diff[DATA_W] set means the subtract
        // went negative.
        diff     = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};
        quot_fix = (neg1 ^ neg2) ? -work[DATA_W-1:0] : work[DATA_W-1:0];
        rem_fix  = neg1 ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];

        case (state)
            S_FREE: begin
                ready_n  = 1'b0;
                result_n = '0;
                if (bus.start_i && !bus.annul_i) begin
                    state_n   = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
                    cnt_n     = '0;
                    divisor_n = divisor_mag;
                    neg1_n    = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
                    neg2_n    = bus.signed_div_i && bus.opdata2_i[DATA_W-1];
                    work_n    = {{DATA_W{1'b0}}, dividend_mag, 1'b0};
                end
            end
            S_BYZERO: begin
                result_n = '0;
                ready_n  = 1'b1;
                state_n  = S_END;
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_n  = S_FREE;
                    ready_n  = 1'b0;
                    result_n = '0;
                    cnt_n    = '0;
                end else if (cnt != LAST_CNT) begin
                    cnt_n = cnt + 1'b1;
                    if (diff[DATA_W]) begin
                        work_n = {work[2*DATA_W-1:0], 1'b0};
                    end else begin
                        work_n = {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
                    end
                end else begin
                    result_n = {rem_fix, quot_fix};
                    ready_n  = 1'b1;
                    state_n  = S_END;
                end
            end
            S_END: begin
                if (!bus.start_i) begin
                    state_n  = S_FREE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end
            default: begin
                state_n = S_FREE;
            end
        endcase
    end

    assign bus.result_o = result;
    assign bus.ready_o  = ready;
    assign bus.busy_o   = (state != S_FREE);
    assign dbg_state    = state;
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: self-checking bench for ex_div_unit.  It applies directed
// table vectors, hand-written annul/reset/annul-in-FREE sequences, and random
// operations checked against an arithmetic reference model.
module tb_ex_div_unit;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ex_div_unit_if dif ();

    ex_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (dif.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference model: divide the magnitudes with plain arithmetic, then
    // apply the DIV sign rules.  A zero divisor yields zero.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        bit na, nb;
        logic [31:0] q32, r32;
        if (b == 32'd0) return 64'd0;
        na = s && a[31];
        nb = s && b[31];
        ma = na ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
        mb = nb ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
        q  = ma / mb;
        r  = ma % mb;
        q32 = q[31:0];
        r32 = r[31:0];
        if (na ^ nb) q32 = -q32;
        if (na) r32 = -r32;
        return {r32, q32};
    endfunction

    // driver: present a request at a negedge with start high
    task automatic drive_req(input bit s, input logic [31:0] a, input logic [31:0] b);
        dif.signed_div_i = s;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.annul_i      = 1'b0;
        dif.start_i      = 1'b1;
    endtask

    // With a request already driven, count edges until ready_o.  Then check
    // the latency, the result, the hold while start_i stays high, and the
    // clear after start_i drops.  Operands are scrambled after acceptance.
    task automatic run_to_ready(input string name, input int exp_lat);
        int n;
        logic [63:0] exp;
        logic [63:0] got;
        n = 0;
        exp = exp_q.pop_front();
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                check({name, "_busy"}, {63'd0, dif.busy_o}, 64'd1);
                dif.opdata1_i    = $urandom;
                dif.opdata2_i    = $urandom;
                dif.signed_div_i = ~dif.signed_div_i;
            end
            if (dif.ready_o) break;
        end
        if (!dif.ready_o) begin
            $display("FAIL %s_timeout: no ready_o after %0d edges, expected at %0d", name, n, exp_lat);
        end
        check({name, "_lat"}, 64'(n), 64'(exp_lat));
        check({name, "_res"}, dif.result_o, exp);
        got = dif.result_o;
        @(posedge clk);
        @(negedge clk);
        check({name, "_hold"}, {dif.result_o, 64'd0} >> 64, got);
        check({name, "_hold_rdy"}, {63'd0, dif.ready_o & dif.busy_o}, 64'd1);
        dif.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, "_clr"}, {dif.result_o[63:2], dif.ready_o, dif.busy_o}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {dif.result_o[63:2], dif.ready_o, dif.busy_o}, 64'd0);
        rst = 1'b0;

        // directed table
        vecs.push_back('{0, 32'd100,        32'd7,          64'h00000002_0000000E, "u_100_7"});
        vecs.push_back('{1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, "s_m7_2"});
        vecs.push_back('{1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, "s_7_m2"});
        vecs.push_back('{0, 32'h1234,       32'd0,          64'h00000000_00000000, "u_divzero"});
        vecs.push_back('{1, 32'hFFFF0000,   32'd0,          64'h00000000_00000000, "s_divzero"});
        vecs.push_back('{1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, "s_overflow"});
        vecs.push_back('{0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, "u_big"});
        vecs.push_back('{0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, "u_max_1"});
        vecs.push_back('{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, "s_m100_m7"});
        vecs.push_back('{0, 32'd0,          32'd5,          64'h00000000_00000000, "u_zero_5"});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_req(vecs[i].s, vecs[i].a, vecs[i].b);
            exp_q.push_back(vecs[i].exp);
            run_to_ready(vecs[i].name, (vecs[i].b == 32'd0) ? 2 : 34);
        end

        // annul when cnt = 10, then an immediate 9 / 3
        begin
            int rdy_seen;
            rdy_seen = 0;
            @(negedge clk);
            drive_req(1'b0, 32'd100, 32'd7);
            for (int k = 0; k < 11; k++) begin
                @(posedge clk);
                @(negedge clk);
                rdy_seen += int'(dif.ready_o);
            end
            dif.annul_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rdy_seen += int'(dif.ready_o);
            check("annul_free", {dif.result_o[63:1], dif.busy_o}, 64'd0);
            check("annul_no_ready", 64'(rdy_seen), 64'd0);
            drive_req(1'b0, 32'd9, 32'd3);
            exp_q.push_back(64'h00000000_00000003);
            run_to_ready("after_annul_9_3", 34);
        end

        // reset when cnt = 20, then a normal request
        @(negedge clk);
        drive_req(1'b1, 32'hFFFFF000, 32'd3);
        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_reset", {dif.result_o[63:2], dif.ready_o, dif.busy_o}, 64'd0);
        rst = 1'b0;
        drive_req(1'b0, 32'd1000, 32'd33);
        exp_q.push_back(ref_div(1'b0, 32'd1000, 32'd33));
        run_to_ready("after_reset", 34);

        // annul held in FREE blocks acceptance
        @(negedge clk);
        drive_req(1'b1, 32'd50, 32'hFFFFFFFB);
        dif.annul_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("annul_in_free", {63'd0, dif.busy_o}, 64'd0);
        dif.annul_i = 1'b0;
        exp_q.push_back(64'h00000000_FFFFFFF6);
        run_to_ready("after_free_annul", 34);

        // randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            bit          s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = -32'($urandom_range(1, 15));
                2: b = 32'd0;
                default: b = $urandom;
            endcase
            @(negedge clk);
            drive_req(s, a, b);
            exp_q.push_back(ref_div(s, a, b));
            run_to_ready($sformatf("rand%0d", i), (b == 32'd0) ? 2 : 34);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
